game_sequencer: RTL and testbench

Multi-round controller for the FPGA reaction game. It takes debounced button levels and a random-number source, and sequences a configurable number of rounds. Each round fetches a target, runs the counting phase at a difficulty-dependent rate, and scores the stop press. It accumulates the total and best error across rounds. Outputs drive the display mux and LED bar logic.

---
 rtl/game_if.sv | 37 +++
 rtl/game_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_if.sv
// ============================================================================
//  Module      : game_if
//  Description : Button, random-source and display/status bundle of the
//                reaction-game sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_sel;
    logic        rnd_ack;
    logic [13:0] rnd_data;
    logic        rnd_req;
    logic [2:0]  state;
    logic [1:0]  mode;
    logic [3:0]  round;
    logic [13:0] target;
    logic [13:0] count;
    logic [13:0] err;
    logic [17:0] total;
    logic [13:0] best;
    logic        done;

    modport master (
        output btn_up, btn_down, btn_sel, rnd_ack, rnd_data,
        input  rnd_req, state, mode, round, target, count, err, total, best, done
    );

    modport slave (
        input  btn_up, btn_down, btn_sel, rnd_ack, rnd_data,
        output rnd_req, state, mode, round, target, count, err, total, best, done
    );
endinterface

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
//  Module      : game_sequencer
//  Description : Multi-round reaction-game controller: target fetch, paced
//                counting, stop scoring, total/best accumulation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int ROUNDS     = 5,
    parameter int TICKS_EASY = 1000000,
    parameter int TICKS_REG  = 200000,
    parameter int TICKS_HARD = 100000
) (
    input  wire logic clk,
    input  wire logic rst,
    game_if.slave     bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SHOW    = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_SCORE   = 3'd4;
    localparam logic [2:0] S_RESULT  = 3'd5;
    localparam logic [2:0] S_SUMMARY = 3'd6;

    localparam logic [19:0] C_TICK_EASY  = 20'(TICKS_EASY - 1);
    localparam logic [19:0] C_TICK_REG   = 20'(TICKS_REG - 1);
    localparam logic [19:0] C_TICK_HARD  = 20'(TICKS_HARD - 1);
    localparam logic [3:0]  C_LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [13:0] C_MAX14      = 14'h3FFF;

    logic        btn_up_q,   btn_up_d;
    logic        btn_down_q, btn_down_d;
    logic        btn_sel_q,  btn_sel_d;
    logic [2:0]  state_q,    state_d;
    logic [1:0]  mode_q,     mode_d;
    logic [3:0]  round_q,    round_d;
    logic [13:0] target_q,   target_d;
    logic [13:0] count_q,    count_d;
    logic [13:0] err_q,      err_d;
    logic [17:0] total_q,    total_d;
    logic [13:0] best_q,     best_d;
    logic [19:0] tick_q,     tick_d;
    logic        rnd_req_q,  rnd_req_d;
    logic        done_q,     done_d;

    logic        w_up_ev, w_down_ev, w_sel_ev;
    logic [19:0] w_tick_max;
    logic [13:0] w_err;

    assign w_up_ev   = bus.btn_up   & ~btn_up_q;
    assign w_down_ev = bus.btn_down & ~btn_down_q;
    assign w_sel_ev  = bus.btn_sel  & ~btn_sel_q;

    always_comb begin
        case (mode_q)
            2'd0:    w_tick_max = C_TICK_EASY;
            2'd1:    w_tick_max = C_TICK_REG;
            default: w_tick_max = C_TICK_HARD;
        endcase
    end

    assign w_err = (count_q >= target_q) ? (count_q - target_q) : (target_q - count_q);

    always_comb begin
        btn_up_d   = bus.btn_up;
        btn_down_d = bus.btn_down;
        btn_sel_d  = bus.btn_sel;
        state_d    = state_q;
        mode_d     = mode_q;
        round_d    = round_q;
        target_d   = target_q;
        count_d    = count_q;
        err_d      = err_q;
        total_d    = total_q;
        best_d     = best_q;
        tick_d     = tick_q;

        case (state_q)
            S_IDLE: begin
                if (w_up_ev && !w_down_ev && mode_q != 2'd2) begin
                    mode_d = mode_q + 2'd1;
                end else if (w_down_ev && !w_up_ev && mode_q != 2'd0) begin
                    mode_d = mode_q - 2'd1;
                end
                if (w_sel_ev) begin
                    state_d = S_FETCH;
                    round_d = 4'd0;
                    total_d = 18'd0;
                    best_d  = C_MAX14;
                    err_d   = 14'd0;
                end
            end
            S_FETCH: begin
                if (bus.rnd_ack) begin
                    // A zero target would make a perfect score trivial.
                    target_d = (bus.rnd_data == 14'd0) ? 14'd1 : bus.rnd_data;
                    count_d  = 14'd0;
                    tick_d   = 20'd0;
                    state_d  = S_SHOW;
                end
            end
            S_SHOW: begin
                if (w_sel_ev) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (tick_q == w_tick_max) begin
                    tick_d = 20'd0;
                    if (count_q != C_MAX14) begin
                        count_d = count_q + 14'd1;
                    end
                end else begin
                    tick_d = tick_q + 20'd1;
                end
                if (w_sel_ev) begin
                    state_d = S_SCORE;
                end
            end
            S_SCORE: begin
                err_d   = w_err;
                total_d = total_q + 18'(w_err);
                if (w_err < best_q) begin
                    best_d = w_err;
                end
                state_d = S_RESULT;
            end
            S_RESULT: begin
                if (w_sel_ev) begin
                    if (round_q == C_LAST_ROUND) begin
                        state_d = S_SUMMARY;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_SUMMARY: begin
                if (w_sel_ev) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so both track transitions with no lag.
        rnd_req_d = (state_d == S_FETCH);
        done_d    = (state_d == S_SUMMARY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
            btn_sel_q  <= 1'b0;
            state_q    <= S_IDLE;
            mode_q     <= 2'd1;
            round_q    <= 4'd0;
            target_q   <= 14'd0;
            count_q    <= 14'd0;
            err_q      <= 14'd0;
            total_q    <= 18'd0;
            best_q     <= C_MAX14;
            tick_q     <= 20'd0;
            rnd_req_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            btn_up_q   <= btn_up_d;
            btn_down_q <= btn_down_d;
            btn_sel_q  <= btn_sel_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            round_q    <= round_d;
            target_q   <= target_d;
            count_q    <= count_d;
            err_q      <= err_d;
            total_q    <= total_d;
            best_q     <= best_d;
            tick_q     <= tick_d;
            rnd_req_q  <= rnd_req_d;
            done_q     <= done_d;
        end
    end

    assign bus.rnd_req = rnd_req_q;
    assign bus.state   = state_q;
    assign bus.mode    = mode_q;
    assign bus.round   = round_q;
    assign bus.target  = target_q;
    assign bus.count   = count_q;
    assign bus.err     = err_q;
    assign bus.total   = total_q;
    assign bus.best    = best_q;
    assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Scoreboard bench for game_sequencer with a game-rule model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    localparam int ROUNDS = 3;
    localparam int TE     = 3;
    localparam int TR     = 4;
    localparam int TH     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    game_if bus ();

    game_sequencer #(
        .ROUNDS     (ROUNDS),
        .TICKS_EASY (TE),
        .TICKS_REG  (TR),
        .TICKS_HARD (TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int count;
        int err;
        int total;
        int best;
    } score_t;

    score_t score_q[$];
    int     target_q[$];

    int checks   = 0;
    int failures = 0;

    int m_mode   = 1;
    int m_total  = 0;
    int m_best   = 16383;
    int m_target = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ticks_for(input int m);
        return (m == 0) ? TE : (m == 1) ? TR : TH;
    endfunction

    // Monitor: compares whenever the DUT presents a new target or a new score.
    initial begin : monitor
        logic [2:0] prev;
        score_t     s;
        int         t;
        prev = 3'd0;
        forever begin
            @(negedge clk);
            if (!rst && bus.state !== prev) begin
                if (bus.state == 3'd2) begin
                    check("show_pending", 32'(target_q.size() > 0), 1);
                    if (target_q.size() > 0) begin
                        t = target_q.pop_front();
                        check("target", 32'(bus.target), t);
                        check("count_clear", 32'(bus.count), 0);
                    end
                end else if (bus.state == 3'd5) begin
                    check("score_pending", 32'(score_q.size() > 0), 1);
                    if (score_q.size() > 0) begin
                        s = score_q.pop_front();
                        check("count", 32'(bus.count), s.count);
                        check("err",   32'(bus.err),   s.err);
                        check("total", 32'(bus.total), s.total);
                        check("best",  32'(bus.best),  s.best);
                    end
                end
            end
            prev = bus.state;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k = 0;
        while (bus.state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(bus.state), 32'(s));
    endtask

    task automatic press(input bit up, input bit down, input bit sel, input bit in_idle);
        bus.btn_up   = up;
        bus.btn_down = down;
        bus.btn_sel  = sel;
        tick(1);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b0;
        tick(1);
        if (in_idle && up && !down && m_mode < 2) m_mode++;
        if (in_idle && down && !up && m_mode > 0) m_mode--;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},   32'(bus.state),   0);
        check({tag, "_mode"},    32'(bus.mode),    1);
        check({tag, "_round"},   32'(bus.round),   0);
        check({tag, "_target"},  32'(bus.target),  0);
        check({tag, "_count"},   32'(bus.count),   0);
        check({tag, "_err"},     32'(bus.err),     0);
        check({tag, "_total"},   32'(bus.total),   0);
        check({tag, "_best"},    32'(bus.best),    16383);
        check({tag, "_rnd_req"}, 32'(bus.rnd_req), 0);
        check({tag, "_done"},    32'(bus.done),    0);
    endtask

    // From FETCH: hold ack low for dly cycles, then acknowledge with data.
    task automatic fetch(input int dly, input int data);
        for (int i = 0; i < dly; i++) begin
            check("rnd_req_wait", 32'(bus.rnd_req), 1);
            tick(1);
        end
        m_target = (data == 0) ? 1 : data;
        target_q.push_back(m_target);
        bus.rnd_ack  = 1'b1;
        bus.rnd_data = 14'(data);
        tick(1);
        bus.rnd_ack  = 1'b0;
        bus.rnd_data = $urandom;
        check("fetch_to_show", 32'(bus.state), 2);
        check("rnd_req_drop",  32'(bus.rnd_req), 0);
    endtask

    // From SHOW: start counting, stop n edges later (n >= 2).
    task automatic run(input int n, input bit poke_up);
        score_t s;
        int     c;
        bus.btn_sel = 1'b1;
        tick(1);
        bus.btn_sel = 1'b0;
        check("enter_run", 32'(bus.state), 3);
        for (int i = 0; i < n - 1; i++) begin
            bus.btn_up = poke_up && (i == 1);
            tick(1);
        end
        bus.btn_up = 1'b0;
        c = n / ticks_for(m_mode);
        if (c > 16383) c = 16383;
        s.count = c;
        s.err   = (c >= m_target) ? c - m_target : m_target - c;
        m_total = m_total + s.err;
        if (s.err < m_best) m_best = s.err;
        s.total = m_total;
        s.best  = m_best;
        score_q.push_back(s);
        bus.btn_sel = 1'b1;
        tick(1);
        bus.btn_sel = 1'b0;
        wait_state(3'd5, 3, "reach_result");
    endtask

    task automatic play_game(input int tgt[ROUNDS], input int len[ROUNDS], input int dly[ROUNDS]);
        press(0, 0, 1, 1);
        check("start_fetch", 32'(bus.state), 1);
        check("start_req",   32'(bus.rnd_req), 1);
        m_total = 0;
        m_best  = 16383;
        for (int r = 0; r < ROUNDS; r++) begin
            fetch(dly[r], tgt[r]);
            press(0, 0, 0, 0);
            run(len[r], 1'b0);
            check("round", 32'(bus.round), 32'(r));
            bus.btn_sel = 1'b1;
            tick(1);
            bus.btn_sel = 1'b0;
            if (r < ROUNDS - 1) begin
                check("next_fetch", 32'(bus.state), 1);
            end else begin
                check("summary", 32'(bus.state), 6);
                check("done_hi", 32'(bus.done), 1);
            end
            tick(1);
        end
        press(0, 0, 1, 0);
        check("back_idle", 32'(bus.state), 0);
        check("done_lo",   32'(bus.done), 0);
        check("total_hold", 32'(bus.total), 32'(m_total));
        check("best_hold",  32'(bus.best),  32'(m_best));
    endtask

    initial begin : stim
        int tgt[ROUNDS];
        int len[ROUNDS];
        int dly[ROUNDS];
        score_t s;

        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_sel  = 1'b0;
        bus.rnd_ack  = 1'b0;
        bus.rnd_data = 14'd0;
        #2 rst = 1'b1;
        #20;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        // Difficulty selection in IDLE.
        for (int i = 0; i < 3; i++) press(1, 0, 0, 1);
        check("mode_up_sat", 32'(bus.mode), 2);
        for (int i = 0; i < 4; i++) press(0, 1, 0, 1);
        check("mode_dn_sat", 32'(bus.mode), 0);
        bus.btn_up = 1'b1;
        tick(100);
        bus.btn_up = 1'b0;
        tick(1);
        m_mode = 1;
        check("mode_hold", 32'(bus.mode), 1);
        press(1, 1, 0, 1);
        check("mode_both", 32'(bus.mode), 1);

        // Directed game: errors 5, 2, 9 in mode 1.
        press(0, 0, 1, 1);
        m_total = 0;
        m_best  = 16383;
        fetch(10, 20);
        press(0, 0, 0, 0);
        run(100, 1'b1);
        check("mode_in_run", 32'(bus.mode), 1);
        check("err_r0", 32'(bus.err), 5);
        press(0, 0, 1, 0);
        fetch(0, 0);
        check("zero_target", 32'(bus.target), 1);
        press(0, 0, 0, 0);
        run(12, 1'b0);
        press(0, 0, 1, 0);
        fetch(3, 30);
        press(0, 0, 0, 0);
        run(156, 1'b0);
        check("game_total", 32'(bus.total), 16);
        check("game_best",  32'(bus.best),  2);
        bus.btn_sel = 1'b1;
        tick(1);
        bus.btn_sel = 1'b0;
        check("game_done", 32'(bus.done), 1);
        tick(1);
        press(0, 0, 1, 0);
        check("game_idle", 32'(bus.state), 0);
        check("game_total_hold", 32'(bus.total), 16);

        // Randomised games.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                press(1'($urandom), 1'($urandom), 0, 1);
                check("rand_mode", 32'(bus.mode), 32'(m_mode));
            end
            for (int r = 0; r < ROUNDS; r++) begin
                tgt[r] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 16383));
                len[r] = $urandom_range(2, 300);
                dly[r] = $urandom_range(0, 5);
            end
            play_game(tgt, len, dly);
        end

        // Count saturation in mode 2, then abort mid-run.
        while (m_mode < 2) press(1, 0, 0, 1);
        check("mode_hard", 32'(bus.mode), 2);
        press(0, 0, 1, 1);
        m_total = 0;
        m_best  = 16383;
        fetch(0, 100);
        press(0, 0, 0, 0);
        run(40000, 1'b0);
        check("sat_count", 32'(bus.count), 16383);
        check("sat_err",   32'(bus.err),   16283);
        press(0, 0, 1, 0);
        fetch(1, $urandom_range(1, 16383));
        press(0, 0, 1, 0);
        check("abort_in_run", 32'(bus.state), 3);
        tick(50);
        #2 rst = 1'b1;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        m_mode = 1;
        tick(3);
        check("abort_idle", 32'(bus.state), 0);
        check("queues_empty", 32'(score_q.size() + target_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
